// File: rtl/brush_motor_encoder.sv
// Quadrature encoder reader for the brush-motor driver: synchronises and
// deglitches A/B, decodes 4x quadrature into a 32-bit signed position,
// measures signed edges per window, and exposes it all on an Avalon-MM slave.
module brush_motor_encoder #(
  parameter int unsigned WINDOW_DEFAULT = 50000,
  parameter int unsigned FILTER_DEFAULT = 4
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset_n,
  input  logic [31:0] avs_ctrl_writedata,
  output logic [31:0] avs_ctrl_readdata,
  input  logic [3:0]  avs_ctrl_byteenable,
  input  logic [2:0]  avs_ctrl_address,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  output logic        avs_ctrl_waitrequest,
  input  logic        enc_A,
  input  logic        enc_B
);

  localparam logic [31:0] ID_VALUE = 32'hEA680004;

  logic [1:0]  ab_s1, ab_s2, cand_q, prev_q;
  logic [8:0]  run_q, cur_len;
  logic        accept, init_q;
  logic [1:0]  bin_prev, bin_new, bin_diff;
  logic        step_up, step_dn, step_pos, step_neg, illegal;
  logic [31:0] step_val;
  logic        enable_q, invert_q;
  logic [7:0]  filter_q, err_cnt_q;
  logic        dir_q, sticky_q;
  logic [31:0] position_q, window_q, win_cnt_q, acc_q, speed_q;
  logic [31:0] readdata_q, rd_mux;
  logic        wr_ctrl, wr_pos, wr_win, wr_filt, clr_pos, clr_err;
  logic [31:0] pos_merged, win_merged;
  logic        unused_read;

  // Reads are not side-effecting, so readdata simply tracks the address.
  assign unused_read          = avs_ctrl_read;
  assign avs_ctrl_waitrequest = 1'b0;
  assign avs_ctrl_readdata    = readdata_q;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Bus write decode and byte-lane merging.
  always_comb begin
    wr_ctrl    = avs_ctrl_write && (avs_ctrl_address == 3'd1);
    wr_pos     = avs_ctrl_write && (avs_ctrl_address == 3'd2);
    wr_win     = avs_ctrl_write && (avs_ctrl_address == 3'd3);
    wr_filt    = avs_ctrl_write && (avs_ctrl_address == 3'd6);
    clr_pos    = wr_ctrl && avs_ctrl_writedata[2];
    clr_err    = wr_ctrl && avs_ctrl_writedata[3];
    pos_merged = be_merge(position_q, avs_ctrl_writedata, avs_ctrl_byteenable);
    win_merged = be_merge(window_q, avs_ctrl_writedata, avs_ctrl_byteenable);
  end

  // Stability run length of the synchronised AB value; accept once it has
  // held for FILTER+1 clocks (the current cycle counts as one).
  always_comb begin
    cur_len = 9'd1;
    if (ab_s2 == cand_q) cur_len = (run_q == '1) ? run_q : run_q + 9'd1;
    accept = (cur_len > {1'b0, filter_q});
  end

  // Quadrature decode: Gray to binary, then the modulo-4 difference gives
  // +1, -1 or an illegal double change.
  always_comb begin
    bin_prev = {prev_q[1], prev_q[1] ^ prev_q[0]};
    bin_new  = {ab_s2[1], ab_s2[1] ^ ab_s2[0]};
    bin_diff = bin_new - bin_prev;
    step_up  = 1'b0;
    step_dn  = 1'b0;
    illegal  = 1'b0;
    if (accept && !init_q && enable_q) begin
      case (bin_diff)
        2'd1:    step_up = 1'b1;
        2'd3:    step_dn = 1'b1;
        2'd2:    illegal = 1'b1;
        default: ;
      endcase
    end
    step_pos = invert_q ? step_dn : step_up;
    step_neg = invert_q ? step_up : step_dn;
    step_val = step_pos ? 32'd1 : (step_neg ? '1 : '0);
  end

  // Two-flop synchronisers and filter run-length tracking.
  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) begin
      ab_s1  <= '0;
      ab_s2  <= '0;
      cand_q <= '0;
      run_q  <= '0;
    end else begin
      ab_s1  <= {enc_A, enc_B};
      ab_s2  <= ab_s1;
      cand_q <= ab_s2;
      run_q  <= cur_len;
    end
  end

  // Previous accepted state; tracked even while disabled so re-enable is clean.
  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) begin
      prev_q <= '0;
      init_q <= 1'b1;
    end else if (accept) begin
      prev_q <= ab_s2;
      init_q <= 1'b0;
    end
  end

  // Control and configuration registers.
  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) begin
      enable_q <= 1'b0;
      invert_q <= 1'b0;
      filter_q <= 8'(FILTER_DEFAULT);
      window_q <= 32'(WINDOW_DEFAULT);
    end else begin
      if (wr_ctrl) begin
        enable_q <= avs_ctrl_writedata[0];
        invert_q <= avs_ctrl_writedata[1];
      end
      if (wr_filt) filter_q <= avs_ctrl_writedata[7:0];
      if (wr_win)  window_q <= win_merged;
    end
  end

  // Position counter: clear beats bus load beats step.
  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n)  position_q <= '0;
    else if (clr_pos)       position_q <= '0;
    else if (wr_pos)        position_q <= pos_merged;
    else                    position_q <= position_q + step_val;
  end

  // Speed window: the step landing on the last count is folded into SPEED.
  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) begin
      win_cnt_q <= 32'(WINDOW_DEFAULT);
      acc_q     <= '0;
      speed_q   <= '0;
    end else if (wr_win) begin
      win_cnt_q <= win_merged;
      acc_q     <= '0;
    end else if (window_q == '0) begin
      win_cnt_q <= '0;
      acc_q     <= '0;
      speed_q   <= '0;
    end else if (win_cnt_q <= 32'd1) begin
      speed_q   <= acc_q + step_val;
      acc_q     <= '0;
      win_cnt_q <= window_q;
    end else begin
      win_cnt_q <= win_cnt_q - 32'd1;
      acc_q     <= acc_q + step_val;
    end
  end

  // Direction and illegal-transition bookkeeping; clear wins over a new error.
  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) begin
      dir_q     <= 1'b0;
      sticky_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (clr_err) begin
        sticky_q  <= 1'b0;
        err_cnt_q <= '0;
      end else if (illegal) begin
        sticky_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
      if (step_pos)      dir_q <= 1'b1;
      else if (step_neg) dir_q <= 1'b0;
    end
  end

  // Read mux.
  always_comb begin
    rd_mux = '0;
    case (avs_ctrl_address)
      3'd0: rd_mux = ID_VALUE;
      3'd1: rd_mux = {30'd0, invert_q, enable_q};
      3'd2: rd_mux = position_q;
      3'd3: rd_mux = window_q;
      3'd4: rd_mux = speed_q;
      3'd5: rd_mux = {16'd0, err_cnt_q, 6'd0, sticky_q, dir_q};
      3'd6: rd_mux = {24'd0, filter_q};
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, held during write cycles.
  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n)   readdata_q <= '0;
    else if (!avs_ctrl_write) readdata_q <= rd_mux;
  end

endmodule

// File: tb/tb_brush_motor_encoder.sv
// Self-checking bench for brush_motor_encoder: bus reads push expectations
// into a scoreboard that is popped when the registered readdata is valid.
module tb_brush_motor_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  byteenable;
  logic [2:0]  address;
  logic        write, read;
  logic        waitrequest;
  logic [1:0]  ab;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] exp;
  } rvec_t;
  rvec_t reset_vecs[8];

  brush_motor_encoder #(
    .WINDOW_DEFAULT(50000),
    .FILTER_DEFAULT(4)
  ) dut (
    .csi_MCLK_clk        (clk),
    .rsi_MRST_reset_n    (rst_n),
    .avs_ctrl_writedata  (writedata),
    .avs_ctrl_readdata   (readdata),
    .avs_ctrl_byteenable (byteenable),
    .avs_ctrl_address    (address),
    .avs_ctrl_write      (write),
    .avs_ctrl_read       (read),
    .avs_ctrl_waitrequest(waitrequest),
    .enc_A               (ab[1]),
    .enc_B               (ab[0])
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] fwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic sb_pop();
    logic [31:0] e;
    string nm;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: empty queue got %h expected entry", readdata);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check_val(nm, readdata, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    @(negedge clk);
    address = a;
    read    = 1'b1;
    write   = 1'b0;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    read = 1'b0;
    sb_pop();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    read       = 1'b0;
    @(negedge clk);
    write      = 1'b0;
    byteenable = 4'hF;
  endtask

  task automatic edges(input int n, input int gap, input bit forward_dir);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ab = forward_dir ? fwd(ab) : rev(ab);
      idle(gap - 1);
    end
  endtask

  // Steady stepping every 5 clocks; the last edge lands on the final iteration.
  task automatic spin(input int n, input bit forward_dir);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c % 5 == 0) ab = forward_dir ? fwd(ab) : rev(ab);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    writedata  = '0;
    byteenable = 4'hF;
    address    = '0;
    write      = 1'b0;
    read       = 1'b0;
    ab         = 2'b00;

    reset_vecs[0] = '{addr: 3'd0, exp: 32'hEA680004};
    reset_vecs[1] = '{addr: 3'd1, exp: 32'h0};
    reset_vecs[2] = '{addr: 3'd2, exp: 32'h0};
    reset_vecs[3] = '{addr: 3'd3, exp: 32'd50000};
    reset_vecs[4] = '{addr: 3'd4, exp: 32'h0};
    reset_vecs[5] = '{addr: 3'd5, exp: 32'h0};
    reset_vecs[6] = '{addr: 3'd6, exp: 32'd4};
    reset_vecs[7] = '{addr: 3'd7, exp: 32'h0};

    idle(4);
    check_val("readdata_in_reset", readdata, 32'h0);
    check_val("waitrequest", {31'd0, waitrequest}, 32'h0);
    rst_n = 1'b1;
    idle(10);

    foreach (reset_vecs[i])
      rd(reset_vecs[i].addr, reset_vecs[i].exp, $sformatf("reset_rd%0d", i));

    // Forward count, then inverted count from zero.
    wr(3'd6, 32'd2, 4'hF);
    wr(3'd1, 32'h1, 4'hF);
    edges(20, 10, 1'b1);
    idle(10);
    rd(3'd2, 32'd20, "fwd_position");
    rd(3'd5, 32'h1, "fwd_status");
    wr(3'd1, 32'h7, 4'hF);
    edges(20, 10, 1'b1);
    idle(10);
    rd(3'd2, 32'hFFFFFFEC, "inv_position");
    rd(3'd5, 32'h0, "inv_status");

    // Glitch rejection with FILTER=4.
    wr(3'd6, 32'd4, 4'hF);
    wr(3'd1, 32'h5, 4'hF);
    @(negedge clk); ab = 2'b10; idle(3); ab = 2'b00;
    idle(20);
    rd(3'd2, 32'h0, "glitch3_position");
    rd(3'd5, 32'h0, "glitch3_status");
    @(negedge clk); ab = 2'b10; idle(6); ab = 2'b00;
    idle(20);
    rd(3'd2, 32'h0, "glitch6_position");
    rd(3'd5, 32'h1, "glitch6_status_dir");

    // Illegal transitions and saturation of the error count.
    wr(3'd6, 32'd0, 4'hF);
    @(negedge clk); ab = ~ab;
    idle(10);
    rd(3'd2, 32'h0, "illegal_position");
    rd(3'd5, 32'h00000103, "illegal_status1");
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); ab = ~ab;
      idle(3);
    end
    idle(10);
    rd(3'd5, 32'h0000FF03, "illegal_sat");
    wr(3'd1, 32'h9, 4'hF);
    rd(3'd5, 32'h00000001, "clr_err_status");

    // Speed over a 100-clock window.
    wr(3'd3, 32'd100, 4'hF);
    spin(301, 1'b1);
    rd(3'd4, 32'd20, "speed_fwd");
    spin(301, 1'b0);
    rd(3'd4, 32'hFFFFFFEC, "speed_rev");
    rd(3'd5, 32'h0, "speed_rev_dir");
    wr(3'd3, 32'd0, 4'hF);
    idle(3);
    rd(3'd4, 32'h0, "speed_window0");

    // Position boundaries and byte lanes.
    wr(3'd2, 32'h7FFFFFFF, 4'hF);
    edges(1, 10, 1'b1);
    rd(3'd2, 32'h80000000, "pos_wrap_max");
    wr(3'd2, 32'hFFFFFFAB, 4'b0001);
    rd(3'd2, 32'h800000AB, "pos_byteenable");
    wr(3'd2, 32'h0, 4'hF);
    edges(1, 10, 1'b0);
    rd(3'd2, 32'hFFFFFFFF, "pos_wrap_zero");

    // clr_pos in the same cycle as a step (FILTER=0: step 3 clocks after pin).
    wr(3'd2, 32'd5, 4'hF);
    @(negedge clk); ab = fwd(ab);
    @(negedge clk);
    @(negedge clk);
    address = 3'd1; writedata = 32'h5; byteenable = 4'hF; write = 1'b1;
    @(negedge clk); write = 1'b0;
    idle(5);
    rd(3'd2, 32'h0, "clr_pos_vs_step");

    // Steps are suppressed while disabled and re-enable adds none.
    wr(3'd1, 32'h0, 4'hF);
    edges(1, 10, 1'b1);
    wr(3'd1, 32'h1, 4'hF);
    idle(10);
    rd(3'd2, 32'h0, "disabled_no_step");
    edges(1, 10, 1'b1);
    rd(3'd2, 32'h1, "reenabled_step");

    wr(3'd3, 32'h00001200, 4'b0010);
    rd(3'd3, 32'h00001200, "window_byteenable");

    // Hold AB=11 through reset release.
    @(negedge clk); rst_n = 1'b0; ab = 2'b11;
    idle(5);
    rst_n = 1'b1;
    idle(20);
    rd(3'd3, 32'd50000, "reset_window_restored");
    wr(3'd1, 32'h1, 4'hF);
    idle(5);
    rd(3'd2, 32'h0, "hold11_position");
    rd(3'd5, 32'h0, "hold11_status");
    @(negedge clk); ab = fwd(ab);
    idle(15);
    rd(3'd2, 32'h1, "hold11_then_fwd");
    rd(3'd5, 32'h1, "hold11_then_fwd_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
